umi_host_rdwr_arb: RTL and testbench
====================================

Name: umi_host_rdwr_arb

Overview:
- Shares one UMI host request/response port pair between an AXI4 read converter and an AXI4 write converter.
- Request side: round-robin arbitration with the grant held to end-of-message, zero-latency pass-through.
- Response side: an in-order route FIFO steers each response back to the requester that issued the matching request.
- Sits between the two AXI-to-UMI converters and the shared UMI host port.

Parameters:
- CW, 32, UMI command width
- AW, 64, address width
- DW, 128, data width
- DEPTH, 8, maximum outstanding non-posted requests; power of two, >=2

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- rd_req_valid/ready  input/output  1  read-requester request handshake
- rd_req_cmd  input  CW  read-requester command
- rd_req_dstaddr, rd_req_srcaddr  input  AW  read-requester addresses
- rd_req_data  input  DW  read-requester data
- wr_req_valid/ready, wr_req_cmd, wr_req_dstaddr, wr_req_srcaddr, wr_req_data  same widths  write-requester request
- rd_resp_valid  output  1  response to read requester
- rd_resp_ready  input  1  read requester accepts response
- rd_resp_cmd  output  CW  response command
- rd_resp_dstaddr, rd_resp_srcaddr  output  AW  response addresses
- rd_resp_data  output  DW  response data
- wr_resp_*  same as rd_resp_*  response to write requester
- uhost_req_valid/ready  output/input  1  shared request handshake
- uhost_req_cmd/dstaddr/srcaddr/data  output  CW/AW/AW/DW  shared request fields
- uhost_resp_valid/ready  input/output  1  shared response handshake
- uhost_resp_cmd/dstaddr/srcaddr/data  input  CW/AW/AW/DW  shared response fields
- outstanding  output  $clog2(DEPTH)+1  route FIFO occupancy
- err_orphan  output  1  sticky: a response arrived with the route FIFO empty

Behaviour:
- Reset state: state=IDLE, rr pointer=READ, FIFO empty, outstanding=0, err_orphan=0. uhost_req_valid, rd/wr_resp_valid and all readies are 0 while nreset is low.
- Fire definitions:
  - req fire = uhost_req_valid & uhost_req_ready.
  - eom = selected cmd[UMI_EOM_BIT].
  - posted = cmd opcode equals UMI_REQ_POSTED.
- Selection:
  - IDLE: choose the valid requester. If both are valid, take the one indicated by the rr pointer.
  - LOCKED: always take the locked owner. Its valid is the only one considered.
- Request path (combinational, zero latency):
  - uhost_req_* = selected requester fields.
  - uhost_req_valid = selected valid & ~block.
  - Selected requester ready = uhost_req_ready & ~block. The other requester's ready = 0.
  - block = FIFO full & ~posted.
- State transitions:
  - IDLE, no fire but selection valid -> LOCKED(selected). Guarantees the request stays stable per UMI rules.
  - IDLE or LOCKED, fire with eom -> IDLE. rr pointer is set to the non-winning requester.
  - Fire without eom -> LOCKED(owner).
- Route FIFO push:
  - On req fire with eom and ~posted, push owner ID (0=read, 1=write).
  - Multi-packet requests push exactly once, on the EOM packet.
- Response path:
  - FIFO head selects the destination port. uhost_resp_* fields are broadcast to both ports.
  - Only the head port sees valid = uhost_resp_valid & ~empty.
  - uhost_resp_ready = head port resp_ready & ~empty.
- Route FIFO pop: on resp fire with uhost_resp_cmd[UMI_EOM_BIT]=1. Responses without EOM do not pop.
- Orphan response: uhost_resp_valid while FIFO empty sets err_orphan (sticky until reset). uhost_resp_ready stays 0; the response is never dropped silently.
- FIFO full:
  - Non-posted requests stall.
  - Posted requests pass.
  - A pop in the same cycle does not lift the stall; full is evaluated pre-cycle.
- Simultaneous push+pop: occupancy unchanged, both operations performed.
- Pointers wrap modulo DEPTH. outstanding counts 0..DEPTH.
- Reset mid-operation: asynchronous clear to the reset state. Lock and FIFO contents are discarded.

Test Plan:
- Both requesters valid with single-packet eom reads/writes, uhost_req_ready=1 -> grants alternate R,W,R,W; outstanding rises 1..4.
- Write requester sends 3-packet write (eom only on packet 3), read valid throughout, uhost_req_ready toggling -> no read packet interleaves; exactly one FIFO push after packet 3.
- DEPTH=8: 8 reads issued, responses withheld -> 9th read sees rd_req_ready=0; a posted write still fires. One eom response -> the stall lifts next cycle.
- Responses for sequence R,W,R, each a 2-packet response with eom on the second, wr_resp_ready=0 for 5 cycles -> packets delivered in order to rd, wr, rd. uhost_resp_ready is low while wr is stalled.
- uhost_resp_valid=1 with FIFO empty -> err_orphan=1 next cycle and stays 1; uhost_resp_ready=0.
- nreset asserted while LOCKED with outstanding=3 -> all valids/readies 0 immediately; after release, outstanding=0, state IDLE, pointer READ.

Source files
------------

// File: rtl/umi_host_rdwr_arb.sv
// Shares one UMI host port between the AXI read and write converters.
// Round-robin request arbitration locked to EOM; in-order response routing.
module umi_host_rdwr_arb #(
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 128,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [CW-1:0]              rd_req_cmd,
    input  logic [AW-1:0]              rd_req_dstaddr,
    input  logic [AW-1:0]              rd_req_srcaddr,
    input  logic [DW-1:0]              rd_req_data,
    input  logic                       wr_req_valid,
    output logic                       wr_req_ready,
    input  logic [CW-1:0]              wr_req_cmd,
    input  logic [AW-1:0]              wr_req_dstaddr,
    input  logic [AW-1:0]              wr_req_srcaddr,
    input  logic [DW-1:0]              wr_req_data,
    output logic                       rd_resp_valid,
    input  logic                       rd_resp_ready,
    output logic [CW-1:0]              rd_resp_cmd,
    output logic [AW-1:0]              rd_resp_dstaddr,
    output logic [AW-1:0]              rd_resp_srcaddr,
    output logic [DW-1:0]              rd_resp_data,
    output logic                       wr_resp_valid,
    input  logic                       wr_resp_ready,
    output logic [CW-1:0]              wr_resp_cmd,
    output logic [AW-1:0]              wr_resp_dstaddr,
    output logic [AW-1:0]              wr_resp_srcaddr,
    output logic [DW-1:0]              wr_resp_data,
    output logic                       uhost_req_valid,
    input  logic                       uhost_req_ready,
    output logic [CW-1:0]              uhost_req_cmd,
    output logic [AW-1:0]              uhost_req_dstaddr,
    output logic [AW-1:0]              uhost_req_srcaddr,
    output logic [DW-1:0]              uhost_req_data,
    input  logic                       uhost_resp_valid,
    output logic                       uhost_resp_ready,
    input  logic [CW-1:0]              uhost_resp_cmd,
    input  logic [AW-1:0]              uhost_resp_dstaddr,
    input  logic [AW-1:0]              uhost_resp_srcaddr,
    input  logic [DW-1:0]              uhost_resp_data,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_orphan
);

    localparam int         PW             = $clog2(DEPTH);
    localparam int         OW             = PW + 1;
    localparam int         UMI_EOM_BIT    = 22;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state, state_n;
    logic   owner, owner_n;
    logic   rr, rr_n;

    logic          sel_wr;
    logic          sel_valid;
    logic [CW-1:0] sel_cmd;
    logic          eom;
    logic          posted;
    logic          block;
    logic          fire;

    logic          mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [OW-1:0] count;
    logic          full, empty, head;
    logic          push, pop;
    logic          resp_fire;

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            owner <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr    <= rr_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr;
        if (fire && eom) begin
            state_n = IDLE;
            rr_n    = ~sel_wr;
        end else if (fire) begin
            state_n = LOCKED;
            owner_n = sel_wr;
        end else if (state == IDLE && sel_valid) begin
            // Lock so the stalled request is held stable until it fires
            state_n = LOCKED;
            owner_n = sel_wr;
        end
    end

    // Output logic: selection and request steering
    always_comb begin
        sel_wr = 1'b0;
        if (state == LOCKED) begin
            sel_wr = owner;
        end else if (rd_req_valid && wr_req_valid) begin
            sel_wr = rr;
        end else begin
            sel_wr = wr_req_valid;
        end
    end

    assign sel_valid = sel_wr ? wr_req_valid : rd_req_valid;
    assign sel_cmd   = sel_wr ? wr_req_cmd   : rd_req_cmd;
    assign eom       = sel_cmd[UMI_EOM_BIT];
    assign posted    = (sel_cmd[4:0] == UMI_REQ_POSTED);
    assign block     = full & ~posted;

    assign uhost_req_cmd     = sel_cmd;
    assign uhost_req_dstaddr = sel_wr ? wr_req_dstaddr : rd_req_dstaddr;
    assign uhost_req_srcaddr = sel_wr ? wr_req_srcaddr : rd_req_srcaddr;
    assign uhost_req_data    = sel_wr ? wr_req_data    : rd_req_data;

    assign uhost_req_valid = nreset & sel_valid & ~block;
    assign rd_req_ready    = nreset & ~sel_wr & uhost_req_ready & ~block;
    assign wr_req_ready    = nreset &  sel_wr & uhost_req_ready & ~block;
    assign fire            = uhost_req_valid & uhost_req_ready;

    // Route FIFO: one entry per non-posted message, written at its EOM
    assign full  = (count == OW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];
    assign push  = fire & eom & ~posted;
    assign pop   = resp_fire & uhost_resp_cmd[UMI_EOM_BIT];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= sel_wr;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign outstanding = count;

    // Response steering: fields broadcast, valid only to the head owner
    assign rd_resp_cmd     = uhost_resp_cmd;
    assign rd_resp_dstaddr = uhost_resp_dstaddr;
    assign rd_resp_srcaddr = uhost_resp_srcaddr;
    assign rd_resp_data    = uhost_resp_data;
    assign wr_resp_cmd     = uhost_resp_cmd;
    assign wr_resp_dstaddr = uhost_resp_dstaddr;
    assign wr_resp_srcaddr = uhost_resp_srcaddr;
    assign wr_resp_data    = uhost_resp_data;

    assign rd_resp_valid = nreset & uhost_resp_valid & ~empty & ~head;
    assign wr_resp_valid = nreset & uhost_resp_valid & ~empty &  head;

    assign uhost_resp_ready = nreset & ~empty &
                              (head ? wr_resp_ready : rd_resp_ready);
    assign resp_fire        = uhost_resp_valid & uhost_resp_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_orphan <= 1'b0;
        end else if (uhost_resp_valid && empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_umi_host_rdwr_arb.sv
// Directed bench for umi_host_rdwr_arb: arbitration, locking,
// FIFO full stall, response routing, orphan detection and reset.
module tb_umi_host_rdwr_arb;

    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int DEPTH = 8;

    localparam logic [4:0] OP_RD   = 5'h01;
    localparam logic [4:0] OP_WR   = 5'h03;
    localparam logic [4:0] OP_PWR  = 5'h05;
    localparam logic [4:0] OP_RESP = 5'h02;

    logic clk = 1'b0;
    logic nreset;
    logic rd_req_valid, rd_req_ready;
    logic [CW-1:0] rd_req_cmd;
    logic [AW-1:0] rd_req_dstaddr, rd_req_srcaddr;
    logic [DW-1:0] rd_req_data;
    logic wr_req_valid, wr_req_ready;
    logic [CW-1:0] wr_req_cmd;
    logic [AW-1:0] wr_req_dstaddr, wr_req_srcaddr;
    logic [DW-1:0] wr_req_data;
    logic rd_resp_valid, rd_resp_ready;
    logic [CW-1:0] rd_resp_cmd;
    logic [AW-1:0] rd_resp_dstaddr, rd_resp_srcaddr;
    logic [DW-1:0] rd_resp_data;
    logic wr_resp_valid, wr_resp_ready;
    logic [CW-1:0] wr_resp_cmd;
    logic [AW-1:0] wr_resp_dstaddr, wr_resp_srcaddr;
    logic [DW-1:0] wr_resp_data;
    logic uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic [$clog2(DEPTH):0] outstanding;
    logic err_orphan;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    umi_host_rdwr_arb #(
        .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .nreset(nreset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_cmd(rd_req_cmd), .rd_req_dstaddr(rd_req_dstaddr),
        .rd_req_srcaddr(rd_req_srcaddr), .rd_req_data(rd_req_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_cmd(wr_req_cmd), .wr_req_dstaddr(wr_req_dstaddr),
        .wr_req_srcaddr(wr_req_srcaddr), .wr_req_data(wr_req_data),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_cmd(rd_resp_cmd), .rd_resp_dstaddr(rd_resp_dstaddr),
        .rd_resp_srcaddr(rd_resp_srcaddr), .rd_resp_data(rd_resp_data),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .wr_resp_cmd(wr_resp_cmd), .wr_resp_dstaddr(wr_resp_dstaddr),
        .wr_resp_srcaddr(wr_resp_srcaddr), .wr_resp_data(wr_resp_data),
        .uhost_req_valid(uhost_req_valid),
        .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid),
        .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    function automatic logic [CW-1:0] mkcmd(input logic [4:0] op,
                                            input logic eom);
        logic [CW-1:0] c;
        c = '0;
        c[4:0] = op;
        c[22] = eom;
        return c;
    endfunction

    task automatic clear_inputs;
        rd_req_valid = 0; rd_req_cmd = '0; rd_req_dstaddr = '0;
        rd_req_srcaddr = '0; rd_req_data = '0;
        wr_req_valid = 0; wr_req_cmd = '0; wr_req_dstaddr = '0;
        wr_req_srcaddr = '0; wr_req_data = '0;
        rd_resp_ready = 0; wr_resp_ready = 0;
        uhost_req_ready = 0; uhost_resp_valid = 0;
        uhost_resp_cmd = '0; uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0; uhost_resp_data = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        clear_inputs();
        nreset = 0;
        tick();
        tick();
        nreset = 1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        nreset = 0;
        rd_req_valid = 1; rd_req_cmd = mkcmd(OP_RD, 1);
        wr_req_valid = 1; wr_req_cmd = mkcmd(OP_WR, 1);
        uhost_req_ready = 1; rd_resp_ready = 1; wr_resp_ready = 1;
        uhost_resp_valid = 1;
        tick();
        #1;
        checks++;
        if (uhost_req_valid !== 1'b0 || rd_req_ready !== 1'b0 ||
            wr_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got v=%b rr=%b wr=%b exp 0 0 0",
                     uhost_req_valid, rd_req_ready, wr_req_ready);
        end
        checks++;
        if (rd_resp_valid !== 1'b0 || wr_resp_valid !== 1'b0 ||
            uhost_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got rv=%b wv=%b ur=%b exp 0 0 0",
                     rd_resp_valid, wr_resp_valid, uhost_resp_ready);
        end
        checks++;
        if (outstanding !== 0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got out=%0d orph=%b exp 0 0",
                     outstanding, err_orphan);
        end
        clear_inputs();
        tick();
        nreset = 1;
        tick();
    endtask

    task automatic test_round_robin;
        apply_reset();
        rd_req_valid = 1; rd_req_cmd = mkcmd(OP_RD, 1);
        rd_req_dstaddr = 64'h200;
        wr_req_valid = 1; wr_req_cmd = mkcmd(OP_WR, 1);
        wr_req_dstaddr = 64'h100;
        uhost_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] exp_addr;
            exp_addr = (i % 2 == 1) ? 64'h100 : 64'h200;
            #1;
            checks++;
            if (uhost_req_dstaddr !== exp_addr) begin
                errors++;
                $display("FAIL rr_grant%0d got %0h exp %0h",
                         i, uhost_req_dstaddr, exp_addr);
            end
            tick();
            checks++;
            if (outstanding !== i + 1) begin
                errors++;
                $display("FAIL rr_outstanding%0d got %0d exp %0d",
                         i, outstanding, i + 1);
            end
        end
        clear_inputs();
    endtask

    task automatic test_multi_packet;
        int pkt;
        apply_reset();
        wr_req_valid = 1; wr_req_cmd = mkcmd(OP_WR, 0);
        wr_req_dstaddr = 64'd101;
        tick();
        rd_req_valid = 1; rd_req_cmd = mkcmd(OP_RD, 1);
        rd_req_dstaddr = 64'h200;
        pkt = 1;
        for (int c = 0; c < 6; c++) begin
            uhost_req_ready = (c % 2 == 1);
            wr_req_cmd = mkcmd(OP_WR, pkt == 3);
            wr_req_dstaddr = 64'(100 + pkt);
            #1;
            checks++;
            if (uhost_req_dstaddr !== 64'(100 + pkt) ||
                rd_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL multi_lock%0d got addr=%0d rdy=%b exp %0d 0",
                         c, uhost_req_dstaddr, rd_req_ready, 100 + pkt);
            end
            checks++;
            if (wr_req_ready !== (c % 2 == 1) || outstanding !== 0) begin
                errors++;
                $display("FAIL multi_wr%0d got rdy=%b out=%0d exp %b 0",
                         c, wr_req_ready, outstanding, (c % 2 == 1));
            end
            tick();
            if (c % 2 == 1) pkt++;
        end
        wr_req_valid = 0;
        uhost_req_ready = 0;
        #1;
        checks++;
        if (outstanding !== 1) begin
            errors++;
            $display("FAIL multi_push got %0d exp 1", outstanding);
        end
        checks++;
        if (uhost_req_dstaddr !== 64'h200 || uhost_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL multi_release got addr=%0h v=%b exp 200 1",
                     uhost_req_dstaddr, uhost_req_valid);
        end
        clear_inputs();
    endtask

    task automatic test_fifo_full;
        apply_reset();
        rd_req_valid = 1; rd_req_cmd = mkcmd(OP_RD, 1);
        uhost_req_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (rd_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d got %b exp 1", i, rd_req_ready);
            end
            tick();
        end
        checks++;
        if (outstanding !== DEPTH) begin
            errors++;
            $display("FAIL full_count got %0d exp %0d", outstanding, DEPTH);
        end
        rd_req_valid = 0;
        wr_req_valid = 1; wr_req_cmd = mkcmd(OP_PWR, 1);
        #1;
        checks++;
        if (wr_req_ready !== 1'b1 || uhost_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_posted got rdy=%b v=%b exp 1 1",
                     wr_req_ready, uhost_req_valid);
        end
        tick();
        checks++;
        if (outstanding !== DEPTH) begin
            errors++;
            $display("FAIL full_posted_nopush got %0d exp %0d",
                     outstanding, DEPTH);
        end
        wr_req_valid = 0;
        rd_req_valid = 1;
        #1;
        checks++;
        if (rd_req_ready !== 1'b0 || uhost_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_stall got rdy=%b v=%b exp 0 0",
                     rd_req_ready, uhost_req_valid);
        end
        tick();
        uhost_resp_valid = 1; uhost_resp_cmd = mkcmd(OP_RESP, 1);
        rd_resp_ready = 1;
        #1;
        checks++;
        if (uhost_resp_ready !== 1'b1 || rd_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle got urdy=%b rdy=%b exp 1 0",
                     uhost_resp_ready, rd_req_ready);
        end
        tick();
        uhost_resp_valid = 0;
        #1;
        checks++;
        if (outstanding !== DEPTH - 1 || rd_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_lift got out=%0d rdy=%b exp %0d 1",
                     outstanding, rd_req_ready, DEPTH - 1);
        end
        tick();
        checks++;
        if (outstanding !== DEPTH) begin
            errors++;
            $display("FAIL full_refill got %0d exp %0d", outstanding, DEPTH);
        end
        clear_inputs();
    endtask

    task automatic test_resp_order;
        logic exp_dst [6];
        logic exp_eom [6];
        int idx, stall, cyc;
        logic dst, exp_rdy;
        logic [DW-1:0] got;
        exp_dst = '{0, 0, 1, 1, 0, 0};
        exp_eom = '{0, 1, 0, 1, 0, 1};
        apply_reset();
        uhost_req_ready = 1;
        rd_req_cmd = mkcmd(OP_RD, 1);
        wr_req_cmd = mkcmd(OP_WR, 1);
        rd_req_valid = 1; tick();
        rd_req_valid = 0; wr_req_valid = 1; tick();
        wr_req_valid = 0; rd_req_valid = 1; tick();
        rd_req_valid = 0;
        uhost_req_ready = 0;
        checks++;
        if (outstanding !== 3) begin
            errors++;
            $display("FAIL order_issue got %0d exp 3", outstanding);
        end
        rd_resp_ready = 1;
        idx = 0; stall = 0; cyc = 0;
        while (idx < 6 && cyc < 40) begin
            dst = exp_dst[idx];
            exp_rdy = dst ? (stall >= 5) : 1'b1;
            uhost_resp_valid = 1;
            uhost_resp_cmd = mkcmd(OP_RESP, exp_eom[idx]);
            uhost_resp_data = DW'(idx + 1);
            wr_resp_ready = (stall >= 5);
            #1;
            got = dst ? wr_resp_data : rd_resp_data;
            checks++;
            if (rd_resp_valid !== !dst || wr_resp_valid !== dst) begin
                errors++;
                $display("FAIL order_route%0d got rv=%b wv=%b exp %b %b",
                         idx, rd_resp_valid, wr_resp_valid, !dst, dst);
            end
            checks++;
            if (uhost_resp_ready !== exp_rdy || got !== DW'(idx + 1)) begin
                errors++;
                $display("FAIL order_ready%0d got rdy=%b d=%0d exp %b %0d",
                         idx, uhost_resp_ready, got, exp_rdy, idx + 1);
            end
            tick();
            if (dst && stall < 5) stall++;
            if (exp_rdy) idx++;
            cyc++;
        end
        uhost_resp_valid = 0;
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL order_timeout got %0d exp 6", idx);
        end
        #1;
        checks++;
        if (outstanding !== 0) begin
            errors++;
            $display("FAIL order_drain got %0d exp 0", outstanding);
        end
        clear_inputs();
    endtask

    task automatic test_orphan;
        apply_reset();
        uhost_resp_valid = 1; uhost_resp_cmd = mkcmd(OP_RESP, 1);
        rd_resp_ready = 1; wr_resp_ready = 1;
        #1;
        checks++;
        if (uhost_resp_ready !== 1'b0 || rd_resp_valid !== 1'b0 ||
            wr_resp_valid !== 1'b0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_block got ur=%b rv=%b wv=%b e=%b exp 0000",
                     uhost_resp_ready, rd_resp_valid, wr_resp_valid,
                     err_orphan);
        end
        tick();
        uhost_resp_valid = 0;
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set got %b exp 1", err_orphan);
        end
        tick();
        tick();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky got %b exp 1", err_orphan);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        uhost_req_ready = 1;
        rd_req_valid = 1; rd_req_cmd = mkcmd(OP_RD, 1);
        rd_req_dstaddr = 64'h200;
        tick(); tick(); tick();
        rd_req_valid = 0;
        wr_req_valid = 1; wr_req_cmd = mkcmd(OP_WR, 0);
        wr_req_dstaddr = 64'h100;
        tick();
        rd_req_valid = 1;
        uhost_resp_valid = 1; uhost_resp_cmd = mkcmd(OP_RESP, 0);
        rd_resp_ready = 1; wr_resp_ready = 1;
        #1;
        checks++;
        if (outstanding !== 3 || rd_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup got out=%0d rrdy=%b exp 3 0",
                     outstanding, rd_req_ready);
        end
        nreset = 0;
        #1;
        checks++;
        if (uhost_req_valid !== 1'b0 || rd_req_ready !== 1'b0 ||
            wr_req_ready !== 1'b0 || rd_resp_valid !== 1'b0 ||
            wr_resp_valid !== 1'b0 || uhost_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got %b%b%b%b%b%b exp 000000",
                     uhost_req_valid, rd_req_ready, wr_req_ready,
                     rd_resp_valid, wr_resp_valid, uhost_resp_ready);
        end
        checks++;
        if (outstanding !== 0) begin
            errors++;
            $display("FAIL mid_clear got %0d exp 0", outstanding);
        end
        uhost_resp_valid = 0;
        uhost_req_ready = 0;
        wr_req_cmd = mkcmd(OP_WR, 1);
        tick();
        nreset = 1;
        #1;
        checks++;
        if (uhost_req_dstaddr !== 64'h200 || uhost_req_valid !== 1'b1 ||
            outstanding !== 0) begin
            errors++;
            $display("FAIL mid_release got addr=%0h v=%b out=%0d exp 200 1 0",
                     uhost_req_dstaddr, uhost_req_valid, outstanding);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        nreset = 0;
        test_reset();
        test_round_robin();
        test_multi_packet();
        test_fifo_full();
        test_resp_order();
        test_orphan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
